dmem_mmio_responder: RTL and testbench
======================================

// Module: dmem_mmio_responder
// PURPOSE
//  Data-side memory responder for the pipelined mips core's MEM-stage port
//  (mem_writeM / alu_outM / write_data in, read_data out).
//  - Word RAM region.
//  - Memory-mapped I/O: free-running cycle counter, console TX FIFO drained by a
//    valid/ready sink, and a TOHOST halt register that ends simulation runs.
// PARAMETERS
//  RAM_ADDR_BITS  10             RAM depth = 2**RAM_ADDR_BITS 32-bit words
//  FIFO_DEPTH     16             console FIFO entries; power of 2, >=2
//  MMIO_BASE      32'hFFFF_0000  base byte address of MMIO window (64 KiB)
// PORTS
//  clk            in   1   sole clock, rising edge
//  rst            in   1   asynchronous reset, active-high
//  mem_writeM     in   1   store strobe from core MEM stage
//  alu_outM       in   32  byte address from core MEM stage
//  write_data     in   32  store data
//  read_data      out  32  load data, combinational from alu_outM
//  console_data   out  8   FIFO head byte
//  console_valid  out  1   FIFO non-empty
//  console_ready  in   1   sink accepts head this cycle
//  halt           out  1   TOHOST written (sticky)
//  exit_code      out  32  value written to TOHOST
//  err_sticky     out  1   misaligned/unmapped access or FIFO overflow seen
// BEHAVIOUR
//  Reset (async, all registers):
//   - halt=0, exit_code=0, err_sticky=0, cycle counter=0, FIFO empty,
//     console_valid=0, console_data=0.
//   - RAM contents are NOT reset.
//  Address decode on alu_outM:
//   - RAM:  alu_outM[31:RAM_ADDR_BITS+2]==0; word index = alu_outM[RAM_ADDR_BITS+1:2].
//   - MMIO: alu_outM[31:16]==MMIO_BASE[31:16]; register offset = alu_outM[15:0].
//   - Unmapped: read_data=0, write ignored, err_sticky<=1 only if mem_writeM=1.
//  Read:
//   - Zero-latency: read_data is combinational in the same cycle as alu_outM,
//     as required by the core's single-cycle MEM stage.
//   - A read never changes state.
//  Write:
//   - Committed at the rising clk edge when mem_writeM=1.
//   - A load in the following cycle to the same address returns the new value.
//  Misalignment:
//   - alu_outM[1:0]!=0 with mem_writeM=1: write suppressed, err_sticky<=1.
//   - Reads ignore the low two bits.
//  MMIO map (offset: access, function):
//   - 0x0 CYCLE R: free-running 32-bit counter, +1 every cycle. Wraps
//     FFFF_FFFF->0. Read returns the pre-increment value. Writes ignored.
//   - 0x4 CONSOLE_TX W: push write_data[7:0]. Read returns 0.
//   - 0x8 CONSOLE_STATUS R: {22'b0, level[log2(FIFO_DEPTH):0] zero-extended
//     in [9:2], full, empty}; level spans bits [9:2] for FIFO_DEPTH<=128.
//   - 0xC TOHOST R/W: write sets halt<=1 and exit_code<=write_data.
//     - A later write updates exit_code only; halt stays 1 until rst.
//     - Read returns exit_code.
//   - Other offsets in the window: read 0, write ignored, no error.
//  Console FIFO:
//   - Circular buffer with wrapping rd/wr pointers and a level counter
//     of 0..FIFO_DEPTH.
//   - pop = console_valid && console_ready. console_data = head entry;
//     0 when empty.
//   - push (TX write) with level<FIFO_DEPTH: accepted.
//   - push while full and pop the same cycle: accepted, level unchanged.
//   - push while full, no pop: byte dropped, err_sticky<=1.
//   - Simultaneous push+pop at level 1: level stays 1; the new byte is head
//     next cycle.
//   - console_valid/console_data must hold while ready=0.
//  Reset asserted mid-operation: FIFO contents discarded immediately; RAM
//   writes in flight at that edge are not guaranteed.
// CONFIGURATION
//  DMEM_CONSOLE_EN defined:
//   - Console FIFO and CONSOLE_TX/CONSOLE_STATUS registers present,
//     as specified above.
//  DMEM_CONSOLE_EN undefined:
//   - No FIFO storage is built. console_valid=0 and console_data=0 constant.
//   - Offsets 0x4 and 0x8 read 0; writes ignored without error.
//   - console_ready is unused.
//  All other behaviour is identical in both builds.
// TESTING
//  1. Store 32'hDEAD_BEEF to 0x0000_0010, then load 0x0000_0010 next cycle
//     -> read_data=32'hDEAD_BEEF.
//  2. Release rst, read CYCLE at cycles 5 and 9 -> values differ by 4.
//     Force counter to FFFF_FFFF -> next read is 0.
//  3. Push 0x41,0x42,0x43 with console_ready=0 -> STATUS level=3,
//     console_data=0x41 held. Raise ready 3 cycles -> 0x41,0x42,0x43 out,
//     then console_valid=0.
//  4. Push FIFO_DEPTH+1 bytes with ready=0 -> level=FIFO_DEPTH, last byte
//     dropped, err_sticky=1. Repeat with ready=1 on the full-push cycle
//     -> no drop, err_sticky=0.
//  5. Store 32'h0000_0001 to 0xFFFF_000C -> halt=1, exit_code=1 on the next
//     cycle. Assert rst mid-run -> halt=0, exit_code=0, FIFO empty.
//  6. Store to 0x0000_0012 and to 0x8000_0000 -> both writes suppressed,
//     err_sticky=1, RAM word 4 unchanged.
//     Build without DMEM_CONSOLE_EN -> TX write ignored, console_valid
//     stays 0.

Source files
------------

// File: rtl/dmem_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_mmio_responder
// Purpose  : Data-side memory responder for the MEM stage: word RAM plus an
//            MMIO window (cycle counter, console TX FIFO, TOHOST halt).
// Config   : define DMEM_CONSOLE_EN to build the console FIFO and its registers.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_mmio_responder #(
    parameter int          RAM_ADDR_BITS = 10,
    parameter int          FIFO_DEPTH    = 16,
    parameter logic [31:0] MMIO_BASE     = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_writeM,
    input  logic [31:0] alu_outM,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic [7:0]  console_data,
    output logic        console_valid,
    input  logic        console_ready,
    output logic        halt,
    output logic [31:0] exit_code,
    output logic        err_sticky
);

    localparam int          c_RAM_WORDS  = 2 ** RAM_ADDR_BITS;
    localparam logic [13:0] c_OFF_CYCLE  = 14'h0;
    localparam logic [13:0] c_OFF_TX     = 14'h1;
    localparam logic [13:0] c_OFF_STATUS = 14'h2;
    localparam logic [13:0] c_OFF_TOHOST = 14'h3;

    logic [31:0]              r_ram [0:c_RAM_WORDS-1];
    logic [31:0]              r_cycleCount;
    logic                     r_halt;
    logic [31:0]              r_exitCode;
    logic                     r_errSticky;

    logic [RAM_ADDR_BITS-1:0] w_ramIdx;
    logic [13:0]              w_regIdx;
    logic                     w_isRam;
    logic                     w_isMmio;
    logic                     w_aligned;
    logic                     w_store;
    logic                     w_ramWrite;
    logic                     w_hostWrite;
    logic                     w_accessErr;
    logic                     w_fifoOverflow;
    logic [31:0]              w_statusWord;

    // Address decode; reads ignore the byte offset, stores require alignment.
    assign w_ramIdx    = alu_outM[RAM_ADDR_BITS+1:2];
    assign w_regIdx    = alu_outM[15:2];
    assign w_isRam     = (alu_outM[31:RAM_ADDR_BITS+2] == '0);
    assign w_isMmio    = (alu_outM[31:16] == MMIO_BASE[31:16]);
    assign w_aligned   = (alu_outM[1:0] == 2'b00);
    assign w_store     = mem_writeM && w_aligned;
    assign w_ramWrite  = w_store && w_isRam;
    assign w_hostWrite = w_store && w_isMmio && (w_regIdx == c_OFF_TOHOST);
    assign w_accessErr = mem_writeM && (!w_aligned || (!w_isRam && !w_isMmio));

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (w_ramWrite) begin
            r_ram[w_ramIdx] <= write_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycleCount <= '0;
            r_halt       <= 1'b0;
            r_exitCode   <= '0;
            r_errSticky  <= 1'b0;
        end else begin
            r_cycleCount <= r_cycleCount + 32'd1;
            if (w_hostWrite) begin
                r_halt     <= 1'b1;
                r_exitCode <= write_data;
            end
            if (w_accessErr || w_fifoOverflow) begin
                r_errSticky <= 1'b1;
            end
        end
    end

`ifdef DMEM_CONSOLE_EN
    localparam int                 c_PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_PTR_W:0]   c_FULL_LVL = FIFO_DEPTH[c_PTR_W:0];

    logic [7:0]          r_fifoMem [0:FIFO_DEPTH-1];
    logic [c_PTR_W-1:0]  r_rdPtr;
    logic [c_PTR_W-1:0]  r_wrPtr;
    logic [c_PTR_W:0]    r_level;
    logic                w_txWrite;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;

    assign w_txWrite      = w_store && w_isMmio && (w_regIdx == c_OFF_TX);
    assign w_full         = (r_level == c_FULL_LVL);
    assign w_empty        = (r_level == '0);
    assign w_pop          = !w_empty && console_ready;
    // A push into a full FIFO survives only if the head leaves the same cycle.
    assign w_push         = w_txWrite && (!w_full || w_pop);
    assign w_fifoOverflow = w_txWrite && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifoMem[r_wrPtr] <= write_data[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    assign console_valid = !w_empty;
    assign console_data  = w_empty ? 8'h00 : r_fifoMem[r_rdPtr];
    assign w_statusWord  = {22'b0, 8'(r_level), w_full, w_empty};
`else
    logic w_unusedReady;

    assign w_unusedReady  = console_ready;
    assign w_fifoOverflow = 1'b0;
    assign console_valid  = 1'b0;
    assign console_data   = 8'h00;
    assign w_statusWord   = '0;
`endif

    always_comb begin
        read_data = '0;
        if (w_isRam) begin
            read_data = r_ram[w_ramIdx];
        end else if (w_isMmio) begin
            case (w_regIdx)
                c_OFF_CYCLE:  read_data = r_cycleCount;
                c_OFF_STATUS: read_data = w_statusWord;
                c_OFF_TOHOST: read_data = r_exitCode;
                default:      read_data = '0;
            endcase
        end
    end

    assign halt       = r_halt;
    assign exit_code  = r_exitCode;
    assign err_sticky = r_errSticky;

endmodule
`default_nettype wire

// File: tb/tb_dmem_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_mmio_responder
// Purpose  : Directed self-checking bench for dmem_mmio_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_mmio_responder;

    logic        clk;
    logic        rst;
    logic        mem_writeM;
    logic [31:0] alu_outM;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic [7:0]  console_data;
    logic        console_valid;
    logic        console_ready;
    logic        halt;
    logic [31:0] exit_code;
    logic        err_sticky;

    int checks   = 0;
    int failures = 0;

    dmem_mmio_responder dut (
        .clk           (clk),
        .rst           (rst),
        .mem_writeM    (mem_writeM),
        .alu_outM      (alu_outM),
        .write_data    (write_data),
        .read_data     (read_data),
        .console_data  (console_data),
        .console_valid (console_valid),
        .console_ready (console_ready),
        .halt          (halt),
        .exit_code     (exit_code),
        .err_sticky    (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset is released on a falling edge, so the counter reads 0 right after.
    task automatic apply_reset();
        @(negedge clk);
        rst           = 1'b1;
        mem_writeM    = 1'b0;
        console_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        mem_writeM = 1'b1;
        alu_outM   = addr;
        write_data = data;
        @(negedge clk);
        mem_writeM = 1'b0;
    endtask

    task automatic load(input logic [31:0] addr, output logic [31:0] data);
        alu_outM = addr;
        #1;
        data = read_data;
    endtask

    task automatic push_byte(input logic [7:0] b);
        @(negedge clk);
        mem_writeM = 1'b1;
        alu_outM   = 32'hFFFF_0004;
        write_data = {24'h0, b};
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b1; mem_writeM = 1'b0; alu_outM = '0; write_data = '0; console_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (halt !== 1'b0) begin failures++; $display("FAIL reset_halt: got %b expected 0", halt); end
        checks++; if (exit_code !== 32'h0) begin failures++; $display("FAIL reset_exit: got %h expected 0", exit_code); end
        checks++; if (err_sticky !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", err_sticky); end
        checks++; if (console_valid !== 1'b0 || console_data !== 8'h00) begin failures++; $display("FAIL reset_console: got valid=%b data=%h expected 0/00", console_valid, console_data); end
        load(32'hFFFF_0000, v);
        checks++; if (v !== 32'h0) begin failures++; $display("FAIL reset_cycle: got %h expected 0", v); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_ram();
        logic [31:0] v;
        store(32'h0000_0010, 32'hDEAD_BEEF);
        load(32'h0000_0010, v);
        checks++; if (v !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ram_rd: got %h expected deadbeef", v); end
        load(32'h0000_0013, v);
        checks++; if (v !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ram_rd_lowbits: got %h expected deadbeef", v); end
        store(32'h0000_0014, 32'h1234_5678);
        load(32'h0000_0014, v);
        checks++; if (v !== 32'h1234_5678) begin failures++; $display("FAIL ram_rd2: got %h expected 12345678", v); end
        load(32'h0000_0010, v);
        checks++; if (v !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ram_neighbour: got %h expected deadbeef", v); end
        store(32'h0000_0FFC, 32'hA5A5_0FFC);
        load(32'h0000_0FFC, v);
        checks++; if (v !== 32'hA5A5_0FFC) begin failures++; $display("FAIL ram_top: got %h expected a5a50ffc", v); end
        load(32'h0000_1000, v);
        checks++; if (v !== 32'h0) begin failures++; $display("FAIL ram_beyond: got %h expected 0", v); end
        checks++; if (err_sticky !== 1'b0) begin failures++; $display("FAIL ram_noerr: got %b expected 0", err_sticky); end
    endtask

    task automatic test_cycle();
        logic [31:0] v5;
        logic [31:0] v9;
        logic [31:0] v;
        apply_reset();
        load(32'hFFFF_0000, v);
        checks++; if (v !== 32'd0) begin failures++; $display("FAIL cycle_start: got %0d expected 0", v); end
        repeat (5) @(negedge clk);
        load(32'hFFFF_0000, v5);
        checks++; if (v5 !== 32'd5) begin failures++; $display("FAIL cycle_5: got %0d expected 5", v5); end
        repeat (4) @(negedge clk);
        load(32'hFFFF_0000, v9);
        checks++; if (v9 - v5 !== 32'd4) begin failures++; $display("FAIL cycle_delta: got %0d expected 4", v9 - v5); end
        store(32'hFFFF_0000, 32'h0000_0123);
        load(32'hFFFF_0000, v);
        checks++; if (v !== 32'd11) begin failures++; $display("FAIL cycle_write_ignored: got %0d expected 11", v); end
        checks++; if (err_sticky !== 1'b0) begin failures++; $display("FAIL cycle_noerr: got %b expected 0", err_sticky); end
    endtask

`ifdef DMEM_CONSOLE_EN
    task automatic test_console();
        logic [31:0] v;
        apply_reset();
        push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
        @(negedge clk);
        mem_writeM = 1'b0;
        load(32'hFFFF_0008, v);
        checks++; if (v !== 32'h0000_000C) begin failures++; $display("FAIL con_status3: got %h expected 0000000c", v); end
        repeat (2) @(negedge clk);
        #1;
        checks++; if (console_valid !== 1'b1 || console_data !== 8'h41) begin failures++; $display("FAIL con_hold: got valid=%b data=%h expected 1/41", console_valid, console_data); end
        console_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (console_data !== 8'h41 + 8'(k)) begin failures++; $display("FAIL con_drain: got %h expected %h", console_data, 8'h41 + 8'(k)); end
            @(negedge clk);
        end
        console_ready = 1'b0;
        #1;
        checks++; if (console_valid !== 1'b0 || console_data !== 8'h00) begin failures++; $display("FAIL con_empty: got valid=%b data=%h expected 0/00", console_valid, console_data); end
        load(32'hFFFF_0008, v);
        checks++; if (v !== 32'h0000_0001) begin failures++; $display("FAIL con_status0: got %h expected 00000001", v); end
        load(32'hFFFF_0004, v);
        checks++; if (v !== 32'h0) begin failures++; $display("FAIL con_txread: got %h expected 0", v); end
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        apply_reset();
        for (int i = 1; i <= 17; i++) push_byte(8'(i));
        @(negedge clk);
        mem_writeM = 1'b0;
        load(32'hFFFF_0008, v);
        checks++; if (v !== 32'h0000_0042) begin failures++; $display("FAIL ovf_status: got %h expected 00000042", v); end
        checks++; if (err_sticky !== 1'b1) begin failures++; $display("FAIL ovf_err: got %b expected 1", err_sticky); end
        console_ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            #1;
            checks++; if (console_data !== 8'(k)) begin failures++; $display("FAIL ovf_drain: got %h expected %h", console_data, 8'(k)); end
            @(negedge clk);
        end
        console_ready = 1'b0;
        #1;
        checks++; if (console_valid !== 1'b0) begin failures++; $display("FAIL ovf_dropped: got valid=%b expected 0", console_valid); end

        apply_reset();
        for (int i = 1; i <= 16; i++) push_byte(8'(i));
        push_byte(8'd17);
        console_ready = 1'b1;
        @(negedge clk);
        mem_writeM    = 1'b0;
        console_ready = 1'b0;
        load(32'hFFFF_0008, v);
        checks++; if (v !== 32'h0000_0042) begin failures++; $display("FAIL fullpop_status: got %h expected 00000042", v); end
        checks++; if (err_sticky !== 1'b0) begin failures++; $display("FAIL fullpop_err: got %b expected 0", err_sticky); end
        console_ready = 1'b1;
        for (int k = 2; k <= 17; k++) begin
            #1;
            checks++; if (console_data !== 8'(k)) begin failures++; $display("FAIL fullpop_drain: got %h expected %h", console_data, 8'(k)); end
            @(negedge clk);
        end
        console_ready = 1'b0;

        apply_reset();
        push_byte(8'h55);
        push_byte(8'h66);
        console_ready = 1'b1;
        @(negedge clk);
        mem_writeM    = 1'b0;
        console_ready = 1'b0;
        load(32'hFFFF_0008, v);
        checks++; if (v !== 32'h0000_0004) begin failures++; $display("FAIL lvl1_status: got %h expected 00000004", v); end
        checks++; if (console_data !== 8'h66) begin failures++; $display("FAIL lvl1_head: got %h expected 66", console_data); end
    endtask
`else
    task automatic test_console_disabled();
        logic [31:0] v;
        apply_reset();
        console_ready = 1'b1;
        store(32'hFFFF_0004, 32'h0000_0041);
        repeat (2) @(negedge clk);
        #1;
        checks++; if (console_valid !== 1'b0 || console_data !== 8'h00) begin failures++; $display("FAIL nocon_out: got valid=%b data=%h expected 0/00", console_valid, console_data); end
        checks++; if (err_sticky !== 1'b0) begin failures++; $display("FAIL nocon_err: got %b expected 0", err_sticky); end
        load(32'hFFFF_0008, v);
        checks++; if (v !== 32'h0) begin failures++; $display("FAIL nocon_status: got %h expected 0", v); end
        load(32'hFFFF_0004, v);
        checks++; if (v !== 32'h0) begin failures++; $display("FAIL nocon_tx: got %h expected 0", v); end
        console_ready = 1'b0;
    endtask
`endif

    task automatic test_errors();
        logic [31:0] v;
        apply_reset();
        store(32'h0000_0012, 32'hCAFE_F00D);
        checks++; if (err_sticky !== 1'b1) begin failures++; $display("FAIL mis_err: got %b expected 1", err_sticky); end
        load(32'h0000_0010, v);
        checks++; if (v !== 32'hDEAD_BEEF) begin failures++; $display("FAIL mis_ram: got %h expected deadbeef", v); end
        apply_reset();
        checks++; if (err_sticky !== 1'b0) begin failures++; $display("FAIL err_cleared: got %b expected 0", err_sticky); end
        load(32'h8000_0000, v);
        checks++; if (err_sticky !== 1'b0 || v !== 32'h0) begin failures++; $display("FAIL unmap_read: got err=%b data=%h expected 0/0", err_sticky, v); end
        store(32'h8000_0000, 32'h1111_2222);
        checks++; if (err_sticky !== 1'b1) begin failures++; $display("FAIL unmap_err: got %b expected 1", err_sticky); end
        load(32'h0000_0000, v);
        checks++; if (v === 32'h1111_2222) begin failures++; $display("FAIL unmap_alias: got %h expected not 11112222", v); end
        apply_reset();
        store(32'hFFFF_0010, 32'h3333_4444);
        load(32'hFFFF_0010, v);
        checks++; if (err_sticky !== 1'b0 || v !== 32'h0) begin failures++; $display("FAIL mmio_other: got err=%b data=%h expected 0/0", err_sticky, v); end
    endtask

    task automatic test_tohost();
        logic [31:0] v;
        apply_reset();
        checks++; if (halt !== 1'b0) begin failures++; $display("FAIL host_prehalt: got %b expected 0", halt); end
        store(32'hFFFF_000C, 32'h0000_0001);
        checks++; if (halt !== 1'b1 || exit_code !== 32'h1) begin failures++; $display("FAIL host_halt: got halt=%b exit=%h expected 1/1", halt, exit_code); end
        load(32'hFFFF_000C, v);
        checks++; if (v !== 32'h1) begin failures++; $display("FAIL host_read: got %h expected 1", v); end
        store(32'hFFFF_000C, 32'h0000_0007);
        checks++; if (halt !== 1'b1 || exit_code !== 32'h7) begin failures++; $display("FAIL host_update: got halt=%b exit=%h expected 1/7", halt, exit_code); end
`ifdef DMEM_CONSOLE_EN
        store(32'hFFFF_0004, 32'h0000_0099);
        checks++; if (console_valid !== 1'b1) begin failures++; $display("FAIL host_fifo_pre: got valid=%b expected 1", console_valid); end
`endif
        #2;
        rst = 1'b1;
        #1;
        checks++; if (halt !== 1'b0 || exit_code !== 32'h0) begin failures++; $display("FAIL host_async_rst: got halt=%b exit=%h expected 0/0", halt, exit_code); end
        checks++; if (console_valid !== 1'b0) begin failures++; $display("FAIL host_rst_fifo: got valid=%b expected 0", console_valid); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ram();
        test_cycle();
`ifdef DMEM_CONSOLE_EN
        test_console();
        test_overflow();
`else
        test_console_disabled();
`endif
        test_errors();
        test_tohost();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
